// File: rtl/health_alert_controller.sv
// health_alert_controller
//   Sequential back end of the healthcare datapath. Debounces the sampled
//   abnormality sources, queues one event per newly confirmed condition in a
//   show-ahead FIFO drained by a valid/ready handshake, and runs a latched
//   alarm FSM with operator acknowledge.
//
// Ports
//   clk, rst             : clock (rising edge), async active-high reset
//   sampleValid          : strobe; sources are evaluated only when 1
//   presureAbnormality   : source 0
//   bloodAbnormality     : source 1
//   glycemicIndex[3:0]   : source 2 asserted when >= GLY_LIMIT
//   lowTempAbnormality   : source 3
//   highTempAbnormality  : source 4
//   fallDetected         : source 5 (confirms on first asserted sample)
//   eventValid/eventReady: FIFO head handshake
//   eventCode[2:0]       : head source index
//   eventData[3:0]       : head payload (latched glycemicIndex for code 2)
//   alarm                : alarm FSM is in ALERT
//   alarmAck             : operator acknowledge; also clears overflow
//   overflow             : sticky, an event was lost
//   activeMask[5:0]      : per-source confirmed flags
module health_alert_controller #(
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int GLY_LIMIT  = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sampleValid,
    input  logic       presureAbnormality,
    input  logic       bloodAbnormality,
    input  logic [3:0] glycemicIndex,
    input  logic       lowTempAbnormality,
    input  logic       highTempAbnormality,
    input  logic       fallDetected,
    output logic       eventValid,
    input  logic       eventReady,
    output logic [2:0] eventCode,
    output logic [3:0] eventData,
    output logic       alarm,
    input  logic       alarmAck,
    output logic       overflow,
    output logic [5:0] activeMask
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [3:0]      DEB_MAX   = 4'(DEBOUNCE);
    localparam logic [3:0]      GLY_TH    = 4'(GLY_LIMIT);
    localparam logic [AW:0]     DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ALERT, ACKED} alarm_state_t;

    alarm_state_t state_q, state_next;

    logic [5:0]  level;
    logic [3:0]  cnt_q    [5];
    logic [3:0]  cnt_next [5];
    logic [5:0]  confirm;
    logic [5:0]  active_q;
    logic [5:0]  pending_q;
    logic [3:0]  gly_hold;

    logic [2:0]  grant_idx;
    logic [5:0]  grant_mask;
    logic        push, pop, full, empty, can_accept;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [6:0]  mem [FIFO_DEPTH];
    logic [6:0]  head;
    logic [3:0]  push_data;

    assign level = {fallDetected, highTempAbnormality, lowTempAbnormality,
                    (glycemicIndex >= GLY_TH), bloodAbnormality, presureAbnormality};

    // Debounce counters and confirmation detect
    always_comb begin
        confirm = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            cnt_next[i] = cnt_q[i];
            if (sampleValid) begin
                if (level[i]) begin
                    cnt_next[i] = (cnt_q[i] >= DEB_MAX) ? DEB_MAX : cnt_q[i] + 4'd1;
                    confirm[i]  = (cnt_next[i] == DEB_MAX) && !active_q[i];
                end else begin
                    cnt_next[i] = '0;
                end
            end
        end
        confirm[5] = sampleValid && fallDetected && !active_q[5];
    end

    // Lowest-index pending source wins the single push slot
    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 6; i > 0; i--) begin
            if (pending_q[i-1]) grant_idx = 3'(i - 1);
        end
    end

    assign full       = ((wr_ptr - rd_ptr) == DEPTH_CNT);
    assign empty      = (wr_ptr == rd_ptr);
    assign pop        = !empty && eventReady;
    assign can_accept = !full || pop;
    assign push       = (pending_q != '0) && can_accept;
    assign grant_mask = push ? (6'b000001 << grant_idx) : '0;
    assign push_data  = (grant_idx == 3'd2) ? gly_hold : 4'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 5; i++) cnt_q[i] <= '0;
            active_q  <= '0;
            pending_q <= '0;
            gly_hold  <= '0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            for (int unsigned i = 0; i < 5; i++) cnt_q[i] <= cnt_next[i];
            for (int unsigned i = 0; i < 6; i++) begin
                if (confirm[i])                   active_q[i] <= 1'b1;
                else if (sampleValid && !level[i]) active_q[i] <= 1'b0;
            end
            // A bit granted this cycle is free again, so a same-cycle
            // re-confirmation of it is not a loss.
            pending_q <= (pending_q & ~grant_mask) | confirm;
            if (confirm[2]) gly_hold <= glycemicIndex;
            if ((confirm & pending_q & ~grant_mask) != '0) overflow <= 1'b1;
            else if (alarmAck)                             overflow <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {grant_idx, push_data};
    end

    assign head       = mem[rd_ptr[AW-1:0]];
    assign eventValid = !empty;
    assign eventCode  = empty ? 3'd0 : head[6:4];
    assign eventData  = empty ? 4'd0 : head[3:0];
    assign activeMask = active_q;

    // Alarm FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE: begin
                if (push) state_next = ALERT;
            end
            ALERT: begin
                if (!push && alarmAck)
                    state_next = (active_q != '0) ? ACKED : IDLE;
            end
            ACKED: begin
                if (push)                  state_next = ALERT;
                else if (active_q == '0)   state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign alarm = (state_q == ALERT);

endmodule

// File: tb/tb_health_alert_controller.sv
module tb_health_alert_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       sampleValid;
    logic       presureAbnormality, bloodAbnormality;
    logic [3:0] glycemicIndex;
    logic       lowTempAbnormality, highTempAbnormality, fallDetected;
    logic       eventValid, eventReady;
    logic [2:0] eventCode;
    logic [3:0] eventData;
    logic       alarm, alarmAck, overflow;
    logic [5:0] activeMask;

    int n_checks = 0;
    int n_fail   = 0;
    logic [6:0] exp_q [$];

    health_alert_controller #(.DEBOUNCE(4), .FIFO_DEPTH(4), .GLY_LIMIT(12)) dut (
        .clk(clk), .rst(rst), .sampleValid(sampleValid),
        .presureAbnormality(presureAbnormality), .bloodAbnormality(bloodAbnormality),
        .glycemicIndex(glycemicIndex), .lowTempAbnormality(lowTempAbnormality),
        .highTempAbnormality(highTempAbnormality), .fallDetected(fallDetected),
        .eventValid(eventValid), .eventReady(eventReady), .eventCode(eventCode),
        .eventData(eventData), .alarm(alarm), .alarmAck(alarmAck),
        .overflow(overflow), .activeMask(activeMask)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [2:0] code, input logic [3:0] data);
        exp_q.push_back({code, data});
    endtask

    // One strobed sample; p,b,lt,ht,f are sources 0,1,3,4,5
    task automatic sample(input logic p, input logic b, input logic [3:0] g,
                          input logic lt, input logic ht, input logic f);
        presureAbnormality  = p;
        bloodAbnormality    = b;
        glycemicIndex       = g;
        lowTempAbnormality  = lt;
        highTempAbnormality = ht;
        fallDetected        = f;
        sampleValid         = 1'b1;
        step();
        sampleValid         = 1'b0;
    endtask

    task automatic ack();
        alarmAck = 1'b1;
        step();
        alarmAck = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int k;
        k = 0;
        while (eventValid && k < bound) begin
            step();
            k++;
        end
        check("drain_timeout", {31'd0, eventValid}, 32'd0);
    endtask

    // Monitor: a pop occurs on the next rising edge whenever valid&ready here
    always @(negedge clk) begin
        if (!rst && eventValid && eventReady) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got code %0d data %0d expected none",
                         eventCode, eventData);
            end else begin
                check("event_code", {29'd0, eventCode}, {29'd0, exp_q[0][6:4]});
                check("event_data", {28'd0, eventData}, {28'd0, exp_q[0][3:0]});
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset with every input driven high
        rst = 1'b1;
        sampleValid = 1'b1; presureAbnormality = 1'b1; bloodAbnormality = 1'b1;
        glycemicIndex = 4'hF; lowTempAbnormality = 1'b1; highTempAbnormality = 1'b1;
        fallDetected = 1'b1; eventReady = 1'b1; alarmAck = 1'b1;
        repeat (3) step();
        check("rst_eventValid", {31'd0, eventValid}, 32'd0);
        check("rst_eventCode",  {29'd0, eventCode},  32'd0);
        check("rst_eventData",  {28'd0, eventData},  32'd0);
        check("rst_alarm",      {31'd0, alarm},      32'd0);
        check("rst_overflow",   {31'd0, overflow},   32'd0);
        check("rst_activeMask", {26'd0, activeMask}, 32'd0);
        sampleValid = 1'b0; presureAbnormality = 1'b0; bloodAbnormality = 1'b0;
        glycemicIndex = 4'd0; lowTempAbnormality = 1'b0; highTempAbnormality = 1'b0;
        fallDetected = 1'b0; eventReady = 1'b0; alarmAck = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Three samples are one short of the debounce window
        repeat (3) sample(1, 0, 0, 0, 0, 0);
        check("short_mask",  {26'd0, activeMask}, 32'd0);
        step();
        check("short_valid", {31'd0, eventValid}, 32'd0);
        sample(0, 0, 0, 0, 0, 0);

        // Debounce of highTemp
        repeat (4) sample(0, 0, 0, 0, 1, 0);
        expect_ev(3'd4, 4'd0);
        check("ht_mask",        {26'd0, activeMask}, 32'h10);
        check("ht_valid_early", {31'd0, eventValid}, 32'd0);
        step();
        check("ht_valid", {31'd0, eventValid}, 32'd1);
        check("ht_alarm", {31'd0, alarm},      32'd1);
        eventReady = 1'b1;
        step();
        eventReady = 1'b0;
        check("ht_popped", {31'd0, eventValid}, 32'd0);
        sample(0, 0, 0, 0, 0, 0);
        check("ht_drop_mask", {26'd0, activeMask}, 32'd0);
        step();
        check("ht_drop_noevent", {31'd0, eventValid}, 32'd0);
        ack();
        check("ack_idle_alarm", {31'd0, alarm}, 32'd0);

        // Glycemic above and below threshold
        eventReady = 1'b1;
        repeat (4) sample(0, 0, 4'd13, 0, 0, 0);
        expect_ev(3'd2, 4'd13);
        check("gly_mask", {26'd0, activeMask}, 32'h04);
        step();
        check("gly_alarm", {31'd0, alarm}, 32'd1);
        step();
        repeat (4) sample(0, 0, 4'd11, 0, 0, 0);
        check("gly_low_mask", {26'd0, activeMask}, 32'd0);
        repeat (2) step();
        check("gly_low_noevent", {31'd0, eventValid}, 32'd0);

        // Fall detected, no debounce
        eventReady = 1'b0;
        sample(0, 0, 0, 0, 0, 1);
        expect_ev(3'd5, 4'd0);
        check("fall_mask",       {26'd0, activeMask}, 32'h20);
        check("fall_valid_edge1", {31'd0, eventValid}, 32'd0);
        step();
        check("fall_valid_edge2", {31'd0, eventValid}, 32'd1);
        eventReady = 1'b1;
        step();
        check("fall_popped", {31'd0, eventValid}, 32'd0);
        sample(0, 0, 0, 0, 0, 0);
        ack();
        check("fall_ack_alarm", {31'd0, alarm}, 32'd0);

        // Simultaneous confirmations of sources 0, 3, 5
        repeat (3) sample(1, 0, 0, 1, 0, 0);
        sample(1, 0, 0, 1, 0, 1);
        expect_ev(3'd0, 4'd0);
        expect_ev(3'd3, 4'd0);
        expect_ev(3'd5, 4'd0);
        check("sim_mask", {26'd0, activeMask}, 32'h29);
        repeat (5) step();
        check("sim_drained", {31'd0, eventValid}, 32'd0);
        sample(0, 0, 0, 0, 0, 0);
        ack();
        check("sim_ack_alarm", {31'd0, alarm}, 32'd0);

        // Full FIFO, pending source and overflow
        eventReady = 1'b0;
        repeat (4) sample(1, 1, 0, 1, 1, 0);
        expect_ev(3'd0, 4'd0);
        expect_ev(3'd1, 4'd0);
        expect_ev(3'd3, 4'd0);
        expect_ev(3'd4, 4'd0);
        repeat (4) step();
        check("full_valid", {31'd0, eventValid}, 32'd1);
        sample(1, 1, 0, 1, 1, 1);
        expect_ev(3'd5, 4'd0);
        step();
        check("pend_no_ovf", {31'd0, overflow}, 32'd0);
        sample(1, 1, 0, 1, 1, 0);
        sample(1, 1, 0, 1, 1, 1);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        eventReady = 1'b1;
        step();
        eventReady = 1'b0;
        check("pop_push_valid", {31'd0, eventValid}, 32'd1);
        check("ovf_sticky",     {31'd0, overflow},   32'd1);
        ack();
        check("ovf_cleared", {31'd0, overflow}, 32'd0);
        check("acked_alarm", {31'd0, alarm},    32'd0);
        eventReady = 1'b1;
        wait_drain(20);

        // Alarm FSM: ACKED -> ALERT on new push
        repeat (4) sample(1, 1, 4'd13, 1, 1, 1);
        expect_ev(3'd2, 4'd13);
        step();
        check("reacked_alarm", {31'd0, alarm}, 32'd1);
        step();
        sample(0, 0, 0, 0, 0, 0);
        ack();
        check("clear_ack_alarm", {31'd0, alarm}, 32'd0);

        // Ack colliding with a push keeps ALERT
        sample(0, 0, 0, 0, 0, 1);
        expect_ev(3'd5, 4'd0);
        step();
        check("pre_collide_alarm", {31'd0, alarm}, 32'd1);
        sample(0, 0, 0, 0, 0, 0);
        sample(0, 0, 0, 0, 0, 1);
        expect_ev(3'd5, 4'd0);
        ack();
        check("collide_alarm", {31'd0, alarm}, 32'd1);
        ack();
        check("plain_ack_alarm", {31'd0, alarm}, 32'd0);
        wait_drain(20);
        step();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/health_alert_controller.md
# health_alert_controller

Sequential back end for the Phase 1 healthcare datapath. Samples the six combinational abnormality outputs of the sensor-evaluation stage on a strobe, debounces each condition, and queues one event per newly confirmed condition in a small FIFO drained over a valid/ready handshake. Also drives a latched alarm FSM with acknowledge for the patient-monitor display and buzzer.

## Interface
- DEBOUNCE, 4: consecutive asserted samples needed to confirm sources 0–4 (range 1–15).
- FIFO_DEPTH, 4: event FIFO entries (power of 2, ≥2).
- GLY_LIMIT, 12: glycemicIndex threshold; source 2 is asserted when glycemicIndex ≥ GLY_LIMIT.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- sampleValid  in  1  strobe; the abnormality inputs are evaluated only on cycles where it is 1.
- presureAbnormality  in  1  source 0.
- bloodAbnormality  in  1  source 1.
- glycemicIndex  in  4  source 2 value.
- lowTempAbnormality  in  1  source 3.
- highTempAbnormality  in  1  source 4.
- fallDetected  in  1  source 5, no debounce.
- eventValid  out  1  FIFO non-empty.
- eventReady  in  1  consumer accepts the head entry.
- eventCode  out  3  head source index 0–5.
- eventData  out  4  head payload: glycemicIndex latched at confirmation for code 2, else 0.
- alarm  out  1  alarm FSM in ALERT.
- alarmAck  in  1  operator acknowledge.
- overflow  out  1  sticky: an event was lost.
- activeMask  out  6  bit i set while source i is confirmed.

## Operation
- Per source i (0–4), a 4-bit saturating counter:
  - On a sampleValid cycle with source asserted: increment, saturating at DEBOUNCE.
  - On a sampleValid cycle with source deasserted: clear the counter and clear activeMask[i]. No event is generated.
  - On cycles without sampleValid: hold.
- Confirmation occurs when the counter reaches DEBOUNCE while activeMask[i]=0. It sets activeMask[i] and pending[i]. For i=2 it also latches glycemicIndex into glyHold.
- Source 5 confirms on the first asserted sample.
- Re-assertion after a clear requires a full new debounce window.
- Arbiter: each cycle, if pending≠0 and the FIFO can accept an entry, push the lowest-index pending source and clear that pending bit. Exactly one push per cycle.
  - The FIFO can accept when it is not full, or when it is full and a pop occurs in the same cycle.
- If a confirmation hits a source whose pending bit is still set, overflow is set. Pending stays set and only one event is queued.
- FIFO is show-ahead: eventCode/eventData reflect the head. A pop happens when eventValid&eventReady. Simultaneous push and pop leaves the count unchanged.
- Alarm FSM states: IDLE, ALERT, ACKED.
  - IDLE → ALERT on any push.
  - ALERT → ACKED on alarmAck when activeMask≠0; ALERT → IDLE on alarmAck when activeMask=0.
  - ACKED → ALERT on any push; ACKED → IDLE when activeMask=0.
  - A push in the same cycle as alarmAck takes priority: the FSM stays in or enters ALERT.
- alarmAck clears overflow, in any state.

## Timing
- Reset values (async, immediate): eventValid=0, eventCode=0, eventData=0, alarm=0, overflow=0, activeMask=0. Counters, pending bits, FIFO pointers and glyHold reset to 0; FSM resets to IDLE.
- Confirming sample on edge T: activeMask updates after T. Push on edge T+1, so eventValid=1 and alarm=1 after T+1, provided the FIFO is not full.
- Fall detected: eventValid is asserted 2 edges after the strobe edge.
- Pop: the new head (or eventValid=0) appears after the accepting edge.
- Reset asserted mid-operation flushes the FIFO and pending events. No event survives reset.
- eventCode/eventData are meaningful only while eventValid=1.

## Test plan
- Reset: drive rst=1 with all inputs at 1 → all outputs 0. Release reset, then strobe presureAbnormality for 3 samples (DEBOUNCE=4) → no event, activeMask=0.
- Debounce: 4 consecutive strobed samples of highTempAbnormality → activeMask=6'b010000. eventCode=4 and eventData=0 are valid 1 cycle later, alarm=1. Dropping the source for one sample clears activeMask[4] and queues no new event.
- Glycemic and fall: glycemicIndex=13 for 4 samples → event with code 2, data 13. glycemicIndex=11 → no event. A single fallDetected sample → code 5 with 2-edge latency.
- Simultaneous confirmations: sources 0, 3 and 5 confirm on the same sample → FIFO entries in order 0, 3, 5 on consecutive cycles. Hold eventReady=1 throughout → all three are drained.
- Full/overflow: eventReady=0, FIFO filled with 4 events. A 5th source confirms → it stays pending. Re-confirming that source → overflow=1. A single pop → the pending source is pushed the same cycle. alarmAck → overflow=0.
- Alarm FSM: ack with activeMask≠0 → alarm=0 (ACKED). A new confirmation → alarm=1. Ack after all sources clear → IDLE. Ack coinciding with a push → alarm stays 1.
